// File: rtl/shared_mem_lsu_pkg.sv
// Shared types for the warp-level shared-memory load/store unit.
// States, access sizes and the latched issue record.
package shared_mem_lsu_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2,
        WRITEBACK = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    // Per-instruction fields kept for the whole transaction
    typedef struct packed {
        logic [5:0]   warp_id;
        logic         write_en;
        access_size_e size;
        logic         sgn;
    } lsu_issue_t;

    // Encoding 3 is folded onto word accesses
    function automatic access_size_e decode_size(input logic [1:0] sz);
        access_size_e r;
        case (sz)
            2'd0:    r = SZ_BYTE;
            2'd1:    r = SZ_HALF;
            default: r = SZ_WORD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shared_mem_lsu_lane_fmt.sv
// Per-lane formatting: byte enables, alignment check, store shift,
// and load byte extraction with sign/zero extension.
module shared_mem_lane_fmt
    import shared_mem_lsu_types::*;
(
    input  logic [31:0]  addr,
    input  access_size_e size,
    input  logic [31:0]  store_data,
    input  logic [1:0]   ld_off,
    input  access_size_e ld_size,
    input  logic         ld_signed,
    input  logic [31:0]  read_data,
    output logic [3:0]   byte_enable,
    output logic         misalign,
    output logic [31:0]  write_data,
    output logic [31:0]  load_data
);

    logic [1:0]  a;
    logic [31:0] shifted;

    assign a = addr[1:0];

    // Request side: enables, alignment and store-data lane placement
    always_comb begin
        byte_enable = 4'h0;
        misalign    = 1'b0;
        write_data  = store_data << {a, 3'b000};
        case (size)
            SZ_BYTE: byte_enable = 4'b0001 << a;
            SZ_HALF: begin
                byte_enable = 4'b0011 << a;
                misalign    = a[0];
            end
            default: begin
                byte_enable = 4'hF;
                misalign    = |a;
            end
        endcase
    end

    // Response side: move the addressed bytes down and extend
    always_comb begin
        shifted   = read_data >> {ld_off, 3'b000};
        load_data = shifted;
        case (ld_size)
            SZ_BYTE: load_data = ld_signed ?
                {{24{shifted[7]}}, shifted[7:0]} :
                {24'h0, shifted[7:0]};
            SZ_HALF: load_data = ld_signed ?
                {{16{shifted[15]}}, shifted[15:0]} :
                {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/shared_mem_lsu.sv
// Warp-level shared-memory initiator: issue, request, response
// collection and per-lane load writeback, with error pulses and counters.
module shared_mem_lsu
    import shared_mem_lsu_types::*;
#(
    parameter int THREADS_PER_WARP = 32,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [5:0]                         issue_warp_id,
    input  logic                               issue_write_en,
    input  logic [1:0]                         issue_size,
    input  logic                               issue_signed,
    input  logic [THREADS_PER_WARP-1:0]        issue_thread_mask,
    input  logic [31:0]                        issue_base_addr,
    input  logic [THREADS_PER_WARP-1:0][31:0]  issue_offset,
    input  logic [THREADS_PER_WARP-1:0][31:0]  issue_store_data,
    output logic [THREADS_PER_WARP-1:0][31:0]  req_address,
    output logic [THREADS_PER_WARP-1:0][31:0]  req_write_data,
    output logic [THREADS_PER_WARP-1:0][3:0]   req_byte_enable,
    output logic [THREADS_PER_WARP-1:0]        req_thread_mask,
    output logic                               req_write_en,
    output logic [5:0]                         req_warp_id,
    output logic                               req_valid,
    input  logic                               req_ready,
    input  logic [THREADS_PER_WARP-1:0][31:0]  resp_read_data,
    input  logic [THREADS_PER_WARP-1:0]        resp_thread_mask,
    input  logic [5:0]                         resp_warp_id,
    input  logic                               resp_valid,
    output logic                               resp_ready,
    output logic                               wb_valid,
    input  logic                               wb_ready,
    output logic [5:0]                         wb_warp_id,
    output logic [THREADS_PER_WARP-1:0]        wb_thread_mask,
    output logic [THREADS_PER_WARP-1:0][31:0]  wb_data,
    output logic                               store_done,
    output logic                               err_misalign,
    output logic                               err_timeout,
    output logic                               err_id,
    output logic                               err_stray,
    output logic [31:0]                        load_count,
    output logic [31:0]                        store_count,
    output logic [31:0]                        misalign_count,
    output logic [31:0]                        timeout_count
);

    localparam int T = THREADS_PER_WARP;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_e state, state_n;
    lsu_issue_t rec;
    logic [T-1:0][1:0] rec_off;
    logic [31:0] timer;

    logic [T-1:0][31:0] lane_addr;
    logic [T-1:0][31:0] lane_wdata;
    logic [T-1:0][31:0] lane_ldata;
    logic [T-1:0][3:0]  lane_be;
    logic [T-1:0]       lane_mis;
    logic [T-1:0]       filt_mask;
    logic [T-1:0]       bad_lanes;
    access_size_e       in_size;

    logic accept, zero_mask, req_fire, wb_fire;
    logic resp_hit, resp_miss, timed_out;
    logic empty_store, empty_load;

    assign in_size     = decode_size(issue_size);
    assign issue_ready = (state == IDLE);
    assign resp_ready  = (state == IDLE) || (state == WAIT_RESP);

    assign accept    = issue_valid && issue_ready;
    assign bad_lanes = issue_thread_mask & lane_mis;
    assign filt_mask = issue_thread_mask & ~lane_mis;
    assign zero_mask = ~|filt_mask;

    assign empty_store = accept && zero_mask && issue_write_en;
    assign empty_load  = accept && zero_mask && !issue_write_en;

    assign req_fire = req_valid && req_ready;
    assign wb_fire  = wb_valid && wb_ready;

    assign resp_hit  = (state == WAIT_RESP) && resp_valid &&
                       (resp_warp_id == rec.warp_id);
    assign resp_miss = (state == WAIT_RESP) && resp_valid &&
                       (resp_warp_id != rec.warp_id);
    assign timed_out = (state == WAIT_RESP) && !resp_hit &&
                       (timer == TMO_LAST);

    for (genvar g = 0; g < T; g++) begin : g_lane
        assign lane_addr[g] = issue_base_addr + issue_offset[g];

        shared_mem_lane_fmt u_fmt (
            .addr        (lane_addr[g]),
            .size        (in_size),
            .store_data  (issue_store_data[g]),
            .ld_off      (rec_off[g]),
            .ld_size     (rec.size),
            .ld_signed   (rec.sgn),
            .read_data   (resp_read_data[g]),
            .byte_enable (lane_be[g]),
            .misalign    (lane_mis[g]),
            .write_data  (lane_wdata[g]),
            .load_data   (lane_ldata[g])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!zero_mask)           state_n = SEND;
                    else if (!issue_write_en) state_n = WRITEBACK;
                end
            end
            SEND: begin
                if (req_fire) state_n = rec.write_en ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_hit)       state_n = WRITEBACK;
                else if (timed_out) state_n = IDLE;
            end
            WRITEBACK: begin
                if (wb_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Latch the issue record and the registered request channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec             <= '0;
            rec_off         <= '0;
            req_valid       <= 1'b0;
            req_address     <= '0;
            req_write_data  <= '0;
            req_byte_enable <= '0;
            req_thread_mask <= '0;
            req_write_en    <= 1'b0;
            req_warp_id     <= '0;
        end else if (accept) begin
            rec <= '{warp_id:  issue_warp_id,
                     write_en: issue_write_en,
                     size:     in_size,
                     sgn:      issue_signed};
            for (int i = 0; i < T; i++) begin
                rec_off[i] <= lane_addr[i][1:0];
            end
            req_valid       <= !zero_mask;
            req_address     <= lane_addr;
            req_write_data  <= lane_wdata;
            req_byte_enable <= lane_be;
            req_thread_mask <= filt_mask;
            req_write_en    <= issue_write_en;
            req_warp_id     <= issue_warp_id;
        end else if (req_fire) begin
            req_valid <= 1'b0;
        end
    end

    // Capture formatted load data and hold it until the register file takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_warp_id     <= '0;
            wb_thread_mask <= '0;
            wb_data        <= '0;
        end else if (empty_load) begin
            wb_valid       <= 1'b1;
            wb_warp_id     <= issue_warp_id;
            wb_thread_mask <= '0;
            wb_data        <= '0;
        end else if (resp_hit) begin
            wb_valid       <= 1'b1;
            wb_warp_id     <= rec.warp_id;
            wb_thread_mask <= resp_thread_mask;
            for (int i = 0; i < T; i++) begin
                wb_data[i] <= resp_thread_mask[i] ? lane_ldata[i] : 32'h0;
            end
        end else if (wb_fire) begin
            wb_valid <= 1'b0;
        end
    end

    // Response timer, cleared whenever not waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     timer <= '0;
        else if (state != WAIT_RESP) timer <= '0;
        else                         timer <= timer + 32'd1;
    end

    // Single-cycle status pulses and wrapping event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_done     <= 1'b0;
            err_misalign   <= 1'b0;
            err_timeout    <= 1'b0;
            err_id         <= 1'b0;
            err_stray      <= 1'b0;
            load_count     <= '0;
            store_count    <= '0;
            misalign_count <= '0;
            timeout_count  <= '0;
        end else begin
            store_done   <= empty_store || (req_fire && rec.write_en);
            err_misalign <= accept && (|bad_lanes);
            err_timeout  <= timed_out;
            err_id       <= resp_miss;
            err_stray    <= (state == IDLE) && resp_valid;
            if (accept && (|bad_lanes))
                misalign_count <= misalign_count + 32'd1;
            if (req_fire && rec.write_en)
                store_count <= store_count + 32'd1;
            if (req_fire && !rec.write_en)
                load_count <= load_count + 32'd1;
            if (timed_out)
                timeout_count <= timeout_count + 32'd1;
        end
    end

endmodule
